// File: rtl/prng_pkg.sv
// ============================================================================
// Module  : prng_pkg
// Brief   : Shared constants, state type and step function for prng_lfsr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package prng_pkg;

    localparam logic [31:0] PRNG_DEFAULT_TAPS = 32'h8020_0003;
    localparam logic [31:0] PRNG_DEFAULT_SEED = 32'hACE1_ACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } prng_lfsr_state_t;

    // One right-shift Galois step: shift out bit 0, fold the taps back in when it was set.
    function automatic logic [31:0] prng_lfsr_next(input logic [31:0] s, input logic [31:0] taps);
        return (s >> 1) ^ (s[0] ? taps : 32'h0000_0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prng_lfsr.sv
// ============================================================================
// Module  : prng_lfsr
// Brief   : 32-bit Galois LFSR with byte-serial seed load (index from an
//           external prng_counter) and a valid/ready random-word output.
//           Optional PRNG_LFSR_STEP_COUNT_EN adds a handshake counter output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prng_lfsr
    import prng_pkg::*;
#(
    parameter logic [31:0] TAPS         = PRNG_DEFAULT_TAPS,
    parameter logic [31:0] DEFAULT_SEED = PRNG_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        stop,
    input  logic        seed_valid,
    input  logic [7:0]  seed_byte,
    output logic        seed_ready,
    output logic        cnt_en,
    input  logic [1:0]  cnt,
    output logic        rnd_valid,
    input  logic        rnd_ready,
    output logic [31:0] rnd
`ifdef PRNG_LFSR_STEP_COUNT_EN
    ,
    output logic [31:0] step_cnt
`endif
);

    prng_lfsr_state_t state;
    logic [31:0]      lfsr;
    logic [31:0]      seed_buf;
    logic [31:0]      seed_word;
    logic             seed_done;
    logic             rnd_fire;

    assign seed_ready = (state != RUN);
    assign cnt_en     = (state != RUN) && seed_valid;
    assign seed_done  = cnt_en && (cnt == 2'd3);
    assign rnd_fire   = rnd_valid && rnd_ready;
    assign rnd        = lfsr;

    // Buffer with the incoming byte already merged, so the last byte can be used the same cycle.
    always_comb begin
        seed_word               = seed_buf;
        seed_word[8*cnt +: 8]   = seed_byte;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            lfsr      <= DEFAULT_SEED;
            seed_buf  <= 32'h0000_0000;
            rnd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (cnt_en) begin
                        seed_buf <= seed_word;
                        if (seed_done) begin
                            lfsr      <= (seed_word == 32'h0000_0000) ? DEFAULT_SEED : seed_word;
                            state     <= RUN;
                            rnd_valid <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end else if ((state == IDLE) && start) begin
                        state     <= RUN;
                        rnd_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (rnd_fire) begin
                        lfsr <= prng_lfsr_next(lfsr, TAPS);
                    end
                    if (stop) begin
                        state     <= IDLE;
                        rnd_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rnd_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PRNG_LFSR_STEP_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rstn || seed_done) begin
            step_cnt <= 32'h0000_0000;
        end else if (rnd_fire) begin
            step_cnt <= step_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_prng_lfsr.sv
// ============================================================================
// Module  : tb_prng_lfsr
// Brief   : Scoreboarded bench for prng_lfsr with a behavioural seed/LFSR
//           model and a local stand-in for prng_counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prng_lfsr;

    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam logic [31:0] DEF  = 32'hACE1_ACE1;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        seed_valid = 1'b0;
    logic [7:0]  seed_byte = 8'h00;
    logic        rnd_ready = 1'b0;
    logic        seed_ready;
    logic        cnt_en;
    logic        rnd_valid;
    logic [31:0] rnd;
    logic [1:0]  cnt;
`ifdef PRNG_LFSR_STEP_COUNT_EN
    logic [31:0] step_cnt;
`endif

    int total = 0;
    int bad = 0;
    int en_pulses = 0;

    logic [31:0] exp_q[$];

    // Reference model: seed as a list of bytes, words as integers.
    logic [31:0]  m_s = DEF;
    bit           m_run = 1'b0;
    byte unsigned m_bytes[$];
    int unsigned  m_steps = 0;

    always #5 clk = ~clk;

    prng_lfsr dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .stop       (stop),
        .seed_valid (seed_valid),
        .seed_byte  (seed_byte),
        .seed_ready (seed_ready),
        .cnt_en     (cnt_en),
        .cnt        (cnt),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd        (rnd)
`ifdef PRNG_LFSR_STEP_COUNT_EN
        ,
        .step_cnt   (step_cnt)
`endif
    );

    // Stand-in for prng_counter.
    always @(posedge clk) begin
        if (!rstn) begin
            cnt <= 2'd0;
        end else if (cnt_en) begin
            cnt       <= cnt + 2'd1;
            en_pulses <= en_pulses + 1;
        end
    end

    function automatic logic [31:0] next_word(input logic [31:0] s);
        return (s / 32'd2) ^ (((s % 32'd2) == 32'd1) ? TAPS : 32'h0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every presented-and-accepted word is popped and compared.
    always @(negedge clk) begin
        if (rstn && rnd_valid && rnd_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rnd_unexpected: got %h expected no handshake at %0t", rnd, $time);
            end else begin
                check("rnd_scoreboard", rnd, exp_q.pop_front());
            end
        end
    end

    // Advance the model on the driven inputs, clock one edge, then compare outputs.
    task automatic tick();
        bit          hs;
        logic [31:0] w;
        hs = rstn && m_run && rnd_ready;
        if (hs) exp_q.push_back(m_s);
        if (!rstn) begin
            m_s = DEF;
            m_run = 1'b0;
            m_bytes.delete();
            m_steps = 0;
        end else if (m_run) begin
            if (hs) begin
                m_s = next_word(m_s);
                m_steps++;
            end
            if (stop) m_run = 1'b0;
        end else if (seed_valid) begin
            m_bytes.push_back(seed_byte);
            if (m_bytes.size() == 4) begin
                w = 32'(m_bytes[0]) | (32'(m_bytes[1]) << 8) |
                    (32'(m_bytes[2]) << 16) | (32'(m_bytes[3]) << 24);
                m_s = (w == 32'h0) ? DEF : w;
                m_run = 1'b1;
                m_bytes.delete();
                m_steps = 0;
            end
        end else if (start && (m_bytes.size() == 0)) begin
            m_run = 1'b1;
        end
        @(posedge clk);
        #1;
        check("rnd_valid", 32'(rnd_valid), 32'(m_run));
        check("seed_ready", 32'(seed_ready), 32'(!m_run));
        check("cnt", 32'(cnt), 32'(m_bytes.size() % 4));
        if (m_run) check("rnd_model", rnd, m_s);
`ifdef PRNG_LFSR_STEP_COUNT_EN
        check("step_cnt", step_cnt, 32'(m_steps));
`endif
    endtask

    task automatic load_word(input logic [31:0] w);
        logic [31:0] v;
        v = w;
        seed_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seed_byte = v[8*i +: 8];
            tick();
        end
        seed_valid = 1'b0;
    endtask

    initial begin
        int          e0;
        logic [31:0] held;

        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        check("reset_rnd", rnd, DEF);
        check("reset_cnt_en", 32'(cnt_en), 32'h0);

        // Start from the reset state.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_word0", rnd, 32'hACE1_ACE1);
        rnd_ready = 1'b1;
        tick();
        check("start_word1", rnd, 32'hD650_D673);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        rnd_ready = 1'b0;
        tick();

        // Byte-serial seed 0x00000001.
        e0 = en_pulses;
        load_word(32'h0000_0001);
        check("seed_cnt_en_pulses", 32'(en_pulses - e0), 32'd4);
        check("seed_cnt_wrap", 32'(cnt), 32'd0);
        check("seed_word0", rnd, 32'h0000_0001);
        rnd_ready = 1'b1;
        tick();
        check("seed_word1", rnd, 32'h8020_0003);
        tick();
        check("seed_word2", rnd, 32'hC030_0002);
        rnd_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // All-zero seed falls back to the default seed.
        load_word(32'h0000_0000);
        check("zero_seed", rnd, 32'hACE1_ACE1);

        // Backpressure holds the word, release steps once per cycle.
        held = rnd;
        repeat (5) tick();
        check("backpressure_hold", rnd, held);
        rnd_ready = 1'b1;
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        rnd_ready = 1'b0;
        check("stop_with_step_idle", 32'(rnd_valid), 32'h0);

        // Reset in the middle of a load.
        seed_valid = 1'b1;
        seed_byte = 8'hAA;
        tick();
        seed_byte = 8'hBB;
        tick();
        seed_valid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("midload_cnt", 32'(cnt), 32'd0);
        check("midload_rnd", rnd, DEF);
        load_word(32'h4433_2211);
        check("midload_reload", rnd, 32'h4433_2211);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Seed byte and start together: seed wins, start ignored.
        seed_valid = 1'b1;
        start = 1'b1;
        seed_byte = 8'h78;
        tick();
        start = 1'b0;
        check("seed_beats_start", 32'(rnd_valid), 32'h0);
        seed_byte = 8'h56;
        tick();
        seed_byte = 8'h34;
        tick();
        seed_byte = 8'h12;
        tick();
        seed_valid = 1'b0;
        check("seed_beats_start_word", rnd, 32'h1234_5678);

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rstn       = ($urandom_range(0, 199) != 0);
            seed_valid = ($urandom_range(0, 2) == 0);
            seed_byte  = 8'($urandom);
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 19) == 0);
            rnd_ready  = ($urandom_range(0, 1) == 1);
            tick();
        end
        rstn = 1'b1;
        seed_valid = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        rnd_ready = 1'b0;
        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
